miter_stream_checker: RTL and testbench
=======================================

# miter_stream_checker

Sequential consumer of the gold/gate output pairs produced by the per-partition equivalence miters of `aes_cipher_top` (e.g. the `output271.Y` output-buffer partition). It sits directly downstream of the miter outputs and streams sampled vectors through an X-tolerant compare. It keeps a sticky verdict, counts mismatches, and captures the first failing sample, so that long simulation or emulation runs of the ASAP7 netlist can be checked without per-cycle assertions. Gold bits that are undefined arrive as an explicit mask, so the block is fully synthesizable.

## Interface
Parameters:
- `WIDTH`, default 128, compared vector width: one bit per miter output pair.
- `CNT_W`, default 16, width of the sample and mismatch counters.

Ports:
- `clk`, input, 1, single clock; all state is updated on the rising edge.
- `rst`, input, 1, asynchronous, active-high reset.
- `start`, input, 1, one-cycle pulse that begins a check session.
- `in_valid`, input, 1, a sample is present on the data inputs.
- `in_ready`, output, 1, the block accepts samples (high only in RUN).
- `in_gold`, input, WIDTH, gold-side miter outputs.
- `in_gate`, input, WIDTH, gate-side miter outputs.
- `in_xmask`, input, WIDTH, 1 = gold bit undefined, so that bit is don't-care.
- `in_last`, input, 1, qualifies the final sample of the session.
- `busy`, output, 1, high while the FSM is in RUN.
- `done`, output, 1, high while the FSM is in DONE.
- `pass`, output, 1, valid only when `done`=1; 1 = zero mismatches.
- `sample_cnt`, output, CNT_W, number of accepted samples; saturating.
- `fail_cnt`, output, CNT_W, number of mismatching samples; saturating.
- `first_idx`, output, CNT_W, index of the first mismatching sample (0-based).
- `first_diff`, output, WIDTH, differing-bit vector of the first mismatching sample.

## Operation
- Accept rule: a sample is accepted when `in_valid && in_ready`.
- Per-bit mismatch is `(in_gold ^ in_gate) & ~in_xmask`.
- A sample mismatches when the OR-reduction of the per-bit vector is 1.
- FSM states:
  - IDLE: go to RUN on `start`; all counters and captures are cleared on entry to RUN.
  - RUN: accept samples. On an accepted sample with `in_last`=1, go to DONE. `start` is ignored.
  - DONE: hold all results. On `start`, clear the results and go to RUN.
- On each accepted sample:
  - `sample_cnt` increments.
  - If the sample mismatches, `fail_cnt` increments.
  - If the sample mismatches and `fail_cnt` was 0, capture `first_idx` = the pre-increment `sample_cnt` and capture `first_diff`.
- Saturation: both counters stop at 2^CNT_W−1 and never wrap. `first_idx` saturates with `sample_cnt`.
- `pass` = (`fail_cnt` == 0), evaluated including the last sample.
- A sample whose mask bits cover every difference counts as a match.
- `in_valid` without `in_ready` (IDLE or DONE) is dropped silently and nothing is counted.

## Timing
- Reset values: FSM in IDLE; `in_ready`, `busy`, `done`, `pass` = 0; `sample_cnt`, `fail_cnt`, `first_idx` = 0; `first_diff` = 0.
- `in_ready` and `busy` are registered state decodes with no combinational path from `in_valid`.
- Latency: counters and captures reflect an accepted sample on the cycle after acceptance.
- `done`/`pass`: asserted on the cycle after the `in_last` acceptance.
- `start` to RUN takes 1 cycle, so `in_ready` rises one cycle after `start`.
- A single-sample session is valid: the first accepted sample carries `in_last`.
- Reset asserted mid-session aborts it asynchronously; all outputs return to their reset values, with no partial verdict kept.

## Structure
- Package `miter_chk_pkg` holds:
  - the state enum `chk_state_e` {IDLE, RUN, DONE};
  - the `CNT_W` default constant;
  - a saturating-increment function used by both counters.
- Sub-module `miter_vec_cmp`: purely combinational. Inputs are gold, gate and xmask; outputs are the diff vector and a mismatch bit, parameterized by `WIDTH`.
- The top level holds the FSM, counters, capture registers and handshake.

## Test plan
- Clean run: start, 4 samples with gold = gate = 128'hA5…, last on the 4th → `done`=1, `pass`=1, `sample_cnt`=4, `fail_cnt`=0.
- Masked difference: gold = 0x1, gate = 0x0, xmask = 0x1, single sample with last → `pass`=1, `fail_cnt`=0.
- First-fail capture: 6 samples; sample 2 differs in bit 7, sample 4 differs in bit 0 → `fail_cnt`=2, `first_idx`=2, `first_diff`=0x80, `pass`=0.
- Saturation: CNT_W=4, 20 mismatching samples → `sample_cnt`=15, `fail_cnt`=15, `first_idx`=0.
- Backpressure and ignore rules:
  - `in_valid` held in IDLE → `sample_cnt` stays 0.
  - `start` pulsed mid-RUN → no clear.
  - `start` in DONE → all results cleared and `in_ready`=1 on the next cycle.
- Async reset mid-RUN after 3 samples → all outputs 0 immediately; the FSM is in IDLE on the next edge.

Source files
------------

// File: rtl/miter_chk_pkg.sv
// Shared types and helpers for the miter stream checker: session FSM states,
// counter width default and the saturating increment used by every counter.
package miter_chk_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } chk_state_e;

    localparam int CNT_W_DEF = 16;

    // Counters of any width up to this are zero-extended into the helper.
    localparam int SAT_MAX_W = 32;

    function automatic logic [SAT_MAX_W-1:0] sat_inc(
        input logic [SAT_MAX_W-1:0] value,
        input logic [SAT_MAX_W-1:0] max_value
    );
        return (value >= max_value) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/miter_vec_cmp.sv
// X-tolerant compare of one gold/gate miter vector pair. Masked gold bits are
// don't-care and can never produce a difference.
module miter_vec_cmp #(
    parameter int WIDTH = 128
) (
    input  logic [WIDTH-1:0] gold,
    input  logic [WIDTH-1:0] gate,
    input  logic [WIDTH-1:0] xmask,
    output logic [WIDTH-1:0] diff,
    output logic             mismatch
);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign diff[gi] = (gold[gi] ^ gate[gi]) & ~xmask[gi];
        end
    endgenerate

    assign mismatch = |diff;

endmodule

// File: rtl/miter_stream_checker.sv
// Streams sampled miter vectors through an X-tolerant compare, keeping a sticky
// verdict, saturating sample/mismatch counters and a capture of the first failure.
module miter_stream_checker
    import miter_chk_pkg::*;
#(
    parameter int WIDTH = 128,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_gold,
    input  logic [WIDTH-1:0] in_gate,
    input  logic [WIDTH-1:0] in_xmask,
    input  logic             in_last,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [CNT_W-1:0] first_idx,
    output logic [WIDTH-1:0] first_diff
);

    localparam logic [SAT_MAX_W-1:0] CNT_MAX = SAT_MAX_W'({CNT_W{1'b1}});

    chk_state_e       state_reg, state_next;
    logic [CNT_W-1:0] sample_cnt_reg, sample_cnt_next;
    logic [CNT_W-1:0] fail_cnt_reg, fail_cnt_next;
    logic [CNT_W-1:0] first_idx_reg, first_idx_next;
    logic [WIDTH-1:0] first_diff_reg, first_diff_next;

    logic [WIDTH-1:0] cmp_diff;
    logic             cmp_mismatch;
    logic             accept;
    logic             clear;

    miter_vec_cmp #(
        .WIDTH (WIDTH)
    ) u_cmp (
        .gold     (in_gold),
        .gate     (in_gate),
        .xmask    (in_xmask),
        .diff     (cmp_diff),
        .mismatch (cmp_mismatch)
    );

    // Handshake is a pure decode of the state register, never of in_valid.
    assign in_ready = (state_reg == RUN);
    assign busy     = (state_reg == RUN);
    assign done     = (state_reg == DONE);
    assign pass     = (state_reg == DONE) && (fail_cnt_reg == '0);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            sample_cnt_reg <= '0;
            fail_cnt_reg   <= '0;
            first_idx_reg  <= '0;
            first_diff_reg <= '0;
        end else begin
            state_reg      <= state_next;
            sample_cnt_reg <= sample_cnt_next;
            fail_cnt_reg   <= fail_cnt_next;
            first_idx_reg  <= first_idx_next;
            first_diff_reg <= first_diff_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        clear      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                    clear      = 1'b1;
                end
            end
            RUN: begin
                if (accept && in_last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    state_next = RUN;
                    clear      = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Clearing only happens outside RUN, so it never collides with an accept.
    always_comb begin
        sample_cnt_next = sample_cnt_reg;
        fail_cnt_next   = fail_cnt_reg;
        first_idx_next  = first_idx_reg;
        first_diff_next = first_diff_reg;
        if (clear) begin
            sample_cnt_next = '0;
            fail_cnt_next   = '0;
            first_idx_next  = '0;
            first_diff_next = '0;
        end else if (accept) begin
            sample_cnt_next = CNT_W'(sat_inc(SAT_MAX_W'(sample_cnt_reg), CNT_MAX));
            if (cmp_mismatch) begin
                fail_cnt_next = CNT_W'(sat_inc(SAT_MAX_W'(fail_cnt_reg), CNT_MAX));
                if (fail_cnt_reg == '0) begin
                    first_idx_next  = sample_cnt_reg;
                    first_diff_next = cmp_diff;
                end
            end
        end
    end

    assign sample_cnt = sample_cnt_reg;
    assign fail_cnt   = fail_cnt_reg;
    assign first_idx  = first_idx_reg;
    assign first_diff = first_diff_reg;

endmodule

// File: tb/tb_miter_stream_checker.sv
// Directed bench for miter_stream_checker: a full-width instance for the session
// scenarios and a narrow CNT_W=4 instance for counter saturation.
module tb_miter_stream_checker;

    logic         clk;
    logic         rst;
    logic         start;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_gold;
    logic [127:0] in_gate;
    logic [127:0] in_xmask;
    logic         in_last;
    logic         busy;
    logic         done;
    logic         pass;
    logic [15:0]  sample_cnt;
    logic [15:0]  fail_cnt;
    logic [15:0]  first_idx;
    logic [127:0] first_diff;

    logic         s_start;
    logic         s_valid;
    logic         s_ready;
    logic [7:0]   s_gold;
    logic [7:0]   s_gate;
    logic [7:0]   s_xmask;
    logic         s_last;
    logic         s_busy;
    logic         s_done;
    logic         s_pass;
    logic [3:0]   s_sample_cnt;
    logic [3:0]   s_fail_cnt;
    logic [3:0]   s_first_idx;
    logic [7:0]   s_first_diff;

    int total;
    int bad;

    localparam logic [127:0] PAT_A5 = {16{8'hA5}};

    miter_stream_checker #(
        .WIDTH (128),
        .CNT_W (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_gold    (in_gold),
        .in_gate    (in_gate),
        .in_xmask   (in_xmask),
        .in_last    (in_last),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .sample_cnt (sample_cnt),
        .fail_cnt   (fail_cnt),
        .first_idx  (first_idx),
        .first_diff (first_diff)
    );

    miter_stream_checker #(
        .WIDTH (8),
        .CNT_W (4)
    ) dut_sat (
        .clk        (clk),
        .rst        (rst),
        .start      (s_start),
        .in_valid   (s_valid),
        .in_ready   (s_ready),
        .in_gold    (s_gold),
        .in_gate    (s_gate),
        .in_xmask   (s_xmask),
        .in_last    (s_last),
        .busy       (s_busy),
        .done       (s_done),
        .pass       (s_pass),
        .sample_cnt (s_sample_cnt),
        .fail_cnt   (s_fail_cnt),
        .first_idx  (s_first_idx),
        .first_diff (s_first_diff)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Stimulus helpers: called just after a rising edge, return #1 after the next one.
    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send(input logic [127:0] g, input logic [127:0] t,
                        input logic [127:0] m, input logic last);
        in_valid = 1'b1;
        in_gold  = g;
        in_gate  = t;
        in_xmask = m;
        in_last  = last;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        $display("txn: gold=%h gate=%h xmask=%h last=%0b -> sample_cnt=%0d fail_cnt=%0d",
                 g, t, m, last, sample_cnt, fail_cnt);
    endtask

    task automatic test_reset();
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        total++; if (pass !== 1'b0) begin bad++; $display("FAIL reset_pass got=%b want=0", pass); end
        total++; if (sample_cnt !== 16'd0) begin bad++; $display("FAIL reset_sample_cnt got=%0d want=0", sample_cnt); end
        total++; if (fail_cnt !== 16'd0) begin bad++; $display("FAIL reset_fail_cnt got=%0d want=0", fail_cnt); end
        total++; if (first_idx !== 16'd0) begin bad++; $display("FAIL reset_first_idx got=%0d want=0", first_idx); end
        total++; if (first_diff !== 128'd0) begin bad++; $display("FAIL reset_first_diff got=%h want=0", first_diff); end
    endtask

    task automatic test_clean_run();
        pulse_start();
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL clean_ready_after_start got=%b want=1", in_ready); end
        for (int i = 0; i < 4; i++) send(PAT_A5, PAT_A5, 128'd0, i == 3);
        total++; if (done !== 1'b1) begin bad++; $display("FAIL clean_done got=%b want=1", done); end
        total++; if (pass !== 1'b1) begin bad++; $display("FAIL clean_pass got=%b want=1", pass); end
        total++; if (sample_cnt !== 16'd4) begin bad++; $display("FAIL clean_sample_cnt got=%0d want=4", sample_cnt); end
        total++; if (fail_cnt !== 16'd0) begin bad++; $display("FAIL clean_fail_cnt got=%0d want=0", fail_cnt); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL clean_ready_in_done got=%b want=0", in_ready); end
    endtask

    task automatic test_masked();
        pulse_start();
        total++; if (sample_cnt !== 16'd0) begin bad++; $display("FAIL masked_cleared got=%0d want=0", sample_cnt); end
        send(128'h1, 128'h0, 128'h1, 1'b1);
        total++; if (done !== 1'b1) begin bad++; $display("FAIL masked_done got=%b want=1", done); end
        total++; if (pass !== 1'b1) begin bad++; $display("FAIL masked_pass got=%b want=1", pass); end
        total++; if (fail_cnt !== 16'd0) begin bad++; $display("FAIL masked_fail_cnt got=%0d want=0", fail_cnt); end
        total++; if (sample_cnt !== 16'd1) begin bad++; $display("FAIL masked_sample_cnt got=%0d want=1", sample_cnt); end
    endtask

    task automatic test_first_fail();
        logic [127:0] g;
        pulse_start();
        for (int i = 0; i < 6; i++) begin
            g = PAT_A5 ^ 128'(i);
            if (i == 2) send(g, g ^ 128'h80, 128'd0, 1'b0);
            else if (i == 4) send(g, g ^ 128'h1, 128'd0, 1'b0);
            else send(g, g, 128'd0, i == 5);
            if (i == 2) begin
                total++; if (fail_cnt !== 16'd1) begin bad++; $display("FAIL ff_latency_fail_cnt got=%0d want=1", fail_cnt); end
                total++; if (busy !== 1'b1) begin bad++; $display("FAIL ff_busy got=%b want=1", busy); end
            end
        end
        total++; if (fail_cnt !== 16'd2) begin bad++; $display("FAIL ff_fail_cnt got=%0d want=2", fail_cnt); end
        total++; if (first_idx !== 16'd2) begin bad++; $display("FAIL ff_first_idx got=%0d want=2", first_idx); end
        total++; if (first_diff !== 128'h80) begin bad++; $display("FAIL ff_first_diff got=%h want=80", first_diff); end
        total++; if (pass !== 1'b0) begin bad++; $display("FAIL ff_pass got=%b want=0", pass); end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL ff_done got=%b want=1", done); end
        total++; if (sample_cnt !== 16'd6) begin bad++; $display("FAIL ff_sample_cnt got=%0d want=6", sample_cnt); end
    endtask

    task automatic test_backpressure();
        // Valid held while in DONE must be dropped.
        for (int i = 0; i < 3; i++) send(128'hF, 128'h0, 128'd0, 1'b1);
        total++; if (sample_cnt !== 16'd6) begin bad++; $display("FAIL bp_done_drop got=%0d want=6", sample_cnt); end
        total++; if (fail_cnt !== 16'd2) begin bad++; $display("FAIL bp_done_fail got=%0d want=2", fail_cnt); end
        pulse_start();
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_restart_ready got=%b want=1", in_ready); end
        total++; if (first_diff !== 128'd0) begin bad++; $display("FAIL bp_restart_diff got=%h want=0", first_diff); end
        total++; if (fail_cnt !== 16'd0) begin bad++; $display("FAIL bp_restart_fail got=%0d want=0", fail_cnt); end
        send(PAT_A5, PAT_A5, 128'd0, 1'b0);
        send(PAT_A5, PAT_A5, 128'd0, 1'b0);
        pulse_start();
        total++; if (sample_cnt !== 16'd2) begin bad++; $display("FAIL bp_midrun_start got=%0d want=2", sample_cnt); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL bp_midrun_busy got=%b want=1", busy); end
        send(128'h0, 128'h300, 128'h100, 1'b1);
        total++; if (first_idx !== 16'd2) begin bad++; $display("FAIL bp_midrun_idx got=%0d want=2", first_idx); end
        total++; if (first_diff !== 128'h200) begin bad++; $display("FAIL bp_midrun_diff got=%h want=200", first_diff); end
        total++; if (sample_cnt !== 16'd3) begin bad++; $display("FAIL bp_midrun_cnt got=%0d want=3", sample_cnt); end
    endtask

    task automatic test_async_reset();
        pulse_start();
        send(PAT_A5, PAT_A5, 128'd0, 1'b0);
        send(PAT_A5, ~PAT_A5, 128'd0, 1'b0);
        send(PAT_A5, PAT_A5, 128'd0, 1'b0);
        total++; if (sample_cnt !== 16'd3) begin bad++; $display("FAIL ar_pre_cnt got=%0d want=3", sample_cnt); end
        #2;
        rst = 1'b1;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ar_busy got=%b want=0", busy); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL ar_ready got=%b want=0", in_ready); end
        total++; if (sample_cnt !== 16'd0) begin bad++; $display("FAIL ar_sample_cnt got=%0d want=0", sample_cnt); end
        total++; if (fail_cnt !== 16'd0) begin bad++; $display("FAIL ar_fail_cnt got=%0d want=0", fail_cnt); end
        total++; if (first_diff !== 128'd0) begin bad++; $display("FAIL ar_first_diff got=%h want=0", first_diff); end
        total++; if (first_idx !== 16'd0) begin bad++; $display("FAIL ar_first_idx got=%0d want=0", first_idx); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL ar_idle got=done%b busy%b want=done0 busy0", done, busy); end
        // Valid held in IDLE must not be counted.
        for (int i = 0; i < 3; i++) send(128'hF, 128'h0, 128'd0, 1'b0);
        total++; if (sample_cnt !== 16'd0) begin bad++; $display("FAIL idle_drop got=%0d want=0", sample_cnt); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL idle_ready got=%b want=0", in_ready); end
    endtask

    task automatic test_saturation();
        s_start = 1'b1;
        @(posedge clk);
        #1;
        s_start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            s_valid = 1'b1;
            s_gold  = 8'hFF;
            s_gate  = 8'h00;
            s_xmask = 8'h0F;
            s_last  = (i == 19);
            @(posedge clk);
            #1;
            $display("txn: sat sample %0d -> sample_cnt=%0d fail_cnt=%0d", i, s_sample_cnt, s_fail_cnt);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        total++; if (s_sample_cnt !== 4'd15) begin bad++; $display("FAIL sat_sample_cnt got=%0d want=15", s_sample_cnt); end
        total++; if (s_fail_cnt !== 4'd15) begin bad++; $display("FAIL sat_fail_cnt got=%0d want=15", s_fail_cnt); end
        total++; if (s_first_idx !== 4'd0) begin bad++; $display("FAIL sat_first_idx got=%0d want=0", s_first_idx); end
        total++; if (s_first_diff !== 8'hF0) begin bad++; $display("FAIL sat_first_diff got=%h want=f0", s_first_diff); end
        total++; if (s_done !== 1'b1 || s_pass !== 1'b0) begin bad++; $display("FAIL sat_verdict got=done%b pass%b want=done1 pass0", s_done, s_pass); end
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_gold  = '0;
        in_gate  = '0;
        in_xmask = '0;
        in_last  = 1'b0;
        s_start  = 1'b0;
        s_valid  = 1'b0;
        s_gold   = '0;
        s_gate   = '0;
        s_xmask  = '0;
        s_last   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        @(posedge clk);
        #1;
        test_clean_run();
        test_masked();
        test_first_fail();
        test_backpressure();
        test_async_reset();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
